// File: rtl/d_sramlike_bridge_pkg.sv
// Shared constants for the M-stage data-port bridge:
// FSM state encoding and sram-like transfer size codes.
package d_sramlike_bridge_pkg;

    typedef logic [1:0] dsbState_t;
    typedef logic [1:0] sramSize_t;

    localparam dsbState_t DSB_IDLE = 2'd0;
    localparam dsbState_t DSB_REQ  = 2'd1;
    localparam dsbState_t DSB_WAIT = 2'd2;
    localparam dsbState_t DSB_DONE = 2'd3;

    localparam sramSize_t SIZE_B = 2'd0;
    localparam sramSize_t SIZE_H = 2'd1;
    localparam sramSize_t SIZE_W = 2'd2;

endpackage

// File: rtl/d_sramlike_if.sv
// Split sram-like request/response bus (req/addr_ok/data_ok).
// master: issues requests; slave: accepts and answers them.
interface d_sramlike_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/d_sramlike_bridge_sram_size_enc.sv
// sram_size_enc: byte write enables -> {size, addr[1:0]}.
// Ports: wen (in), size (out), addrLo (out). wen=0 (load) gives a word.
module sram_size_enc
    import d_sramlike_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output sramSize_t  size,
    output logic [1:0] addrLo
);

    always_comb begin
        size   = SIZE_W;
        addrLo = 2'b00;
        case (wen)
            4'b1111: begin size = SIZE_W; addrLo = 2'b00; end
            4'b0011: begin size = SIZE_H; addrLo = 2'b00; end
            4'b1100: begin size = SIZE_H; addrLo = 2'b10; end
            4'b0001: begin size = SIZE_B; addrLo = 2'b00; end
            4'b0010: begin size = SIZE_B; addrLo = 2'b01; end
            4'b0100: begin size = SIZE_B; addrLo = 2'b10; end
            4'b1000: begin size = SIZE_B; addrLo = 2'b11; end
            // loads and patterns lsmem never emits: whole word
            default: begin size = SIZE_W; addrLo = 2'b00; end
        endcase
    end

endmodule

// File: rtl/d_sramlike_bridge.sv
// M-stage data-port bridge: single-cycle SRAM port -> sram-like bus.
// Ports: clk, rst (async active-low), data_sram_* (datapath side),
// cancel, longest_stall, d_stall, bus (d_sramlike_if.master).
module d_sramlike_bridge
    import d_sramlike_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    input  logic                cancel,
    input  logic                longest_stall,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                d_stall,
    d_sramlike_if.master        bus
);

    dsbState_t         state;
    logic              wrQ;
    sramSize_t         sizeQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] rdataQ;

    sramSize_t  encSize;
    logic [1:0] encLo;
    logic       accept;

    sram_size_enc uSizeEnc (
        .wen    (data_sram_wen[3:0]),
        .size   (encSize),
        .addrLo (encLo)
    );

    assign accept = (state == DSB_IDLE) & data_sram_en & ~cancel;

    // gated by rst so the freeze drops the moment reset asserts
    assign d_stall = rst & (accept |
                            (state == DSB_REQ) |
                            (state == DSB_WAIT));

    assign bus.data_req   = (state == DSB_REQ);
    assign bus.data_wr    = wrQ;
    assign bus.data_size  = sizeQ;
    assign bus.data_addr  = addrQ;
    assign bus.data_wdata = wdataQ;

    assign data_sram_rdata = rdataQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DSB_IDLE;
            wrQ    <= 1'b0;
            sizeQ  <= SIZE_B;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
        end else begin
            unique case (state)
                DSB_IDLE: begin
                    if (accept) begin
                        wrQ    <= |data_sram_wen;
                        sizeQ  <= encSize;
                        addrQ  <= {data_sram_addr[ADDR_W-1:2], encLo};
                        wdataQ <= data_sram_wdata;
                        state  <= DSB_REQ;
                    end
                end
                DSB_REQ: begin
                    // request stays up until the slave takes the address
                    if (bus.data_addr_ok) begin
                        if (bus.data_data_ok) begin
                            if (!wrQ) rdataQ <= bus.data_rdata;
                            state <= DSB_DONE;
                        end else begin
                            state <= DSB_WAIT;
                        end
                    end
                end
                DSB_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (!wrQ) rdataQ <= bus.data_rdata;
                        state <= DSB_DONE;
                    end
                end
                DSB_DONE: begin
                    // hold the result until the whole pipeline moves
                    if (!longest_stall) state <= DSB_IDLE;
                end
            endcase
        end
    end

endmodule
